// File: rtl/mat_scan_sched.sv
// mat_scan_sched: round-robin scheduler that shares one mat_scan zigzag unit
// among N block sources. Each grant is one 64-beat raster burst; scanner
// output is tagged with the source ID of the block it belongs to, and a credit
// counter bounds the number of blocks held inside the scanner.
//
// Transfer semantics: there is no backpressure anywhere on this block. A beat
// is transferred in every cycle its valid is high (gnt[k] towards source k,
// scan_vld_in towards the scanner, scan_vld_out from the scanner, out_vld
// downstream). Sources must therefore supply a sample in every granted cycle,
// and the consumer of out_* must accept every beat.
module mat_scan_sched #(
    parameter int N            = 2,
    parameter int DW           = 10,
    parameter int MAX_INFLIGHT = 2,
    parameter int GAP          = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [N-1:0]    req,
    output logic [N-1:0]    gnt,
    input  logic [N*DW-1:0] src_din,
    output logic            scan_vld_in,
    output logic [DW-1:0]   scan_din,
    input  logic            scan_vld_out,
    input  logic [DW-1:0]   scan_dout,
    output logic            out_vld,
    output logic [DW-1:0]   out_data,
    output logic [2:0]      out_src,
    output logic            out_last,
    output logic [2:0]      inflight,
    output logic            busy,
    output logic            err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam logic [3:0] GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;
    localparam logic [1:0] PTR_LAST = 2'(MAX_INFLIGHT - 1);
    localparam logic [2:0] CREDITS  = 3'(MAX_INFLIGHT);

    state_t          state;
    state_t          state_nxt;
    logic [5:0]      beat;
    logic [3:0]      gap_cnt;
    logic [2:0]      cur_src;     // current / most recent winner, also the RR pointer
    logic            arb_found;
    logic [2:0]      arb_idx;
    logic            can_grant;
    logic            grant;       // a new burst starts on the next edge
    logic            pop;         // last beat of the head block leaves this cycle
    logic            fifo_empty;
    logic [DW-1:0]   sel_din;
    logic [5:0]      out_cnt;
    logic [2:0]      fifo_mem [0:3];
    logic [1:0]      wr_ptr;
    logic [1:0]      rd_ptr;

    function automatic logic [1:0] ptr_next(input logic [1:0] p);
        return (p == PTR_LAST) ? 2'd0 : p + 2'd1;
    endfunction

    // Round-robin search: first requester above the last winner, then wrap.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        for (int k = 0; k < N; k++) begin
            if (!arb_found && req[k] && (3'(k) > cur_src)) begin
                arb_found = 1'b1;
                arb_idx   = 3'(k);
            end
        end
        for (int k = 0; k < N; k++) begin
            if (!arb_found && req[k] && (3'(k) <= cur_src)) begin
                arb_found = 1'b1;
                arb_idx   = 3'(k);
            end
        end
    end

    assign can_grant  = en && arb_found && (inflight < CREDITS);
    assign fifo_empty = (inflight == 3'd0);
    assign pop        = scan_vld_out && !fifo_empty && (out_cnt == 6'd63);
    assign busy       = (state == ST_BURST) || (inflight != 3'd0);

    // Next-state logic; arbitration runs only in IDLE or on the last beat.
    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (can_grant) begin
                    grant     = 1'b1;
                    state_nxt = ST_BURST;
                end
            end
            ST_BURST: begin
                if (beat == 6'd63) begin
                    if (GAP > 0) begin
                        state_nxt = ST_GAP;
                    end else if (can_grant) begin
                        grant     = 1'b1;
                        state_nxt = ST_BURST;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Grant is a decode of the burst state and the winner register.
    always_comb begin
        gnt     = '0;
        sel_din = '0;
        for (int k = 0; k < N; k++) begin
            gnt[k] = (state == ST_BURST) && (cur_src == 3'(k));
            if (cur_src == 3'(k)) begin
                sel_din = src_din[k*DW +: DW];
            end
        end
    end

    // FSM state, beat counter, gap counter and winner register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            beat    <= '0;
            gap_cnt <= '0;
            cur_src <= 3'(N - 1);
        end else begin
            state <= state_nxt;
            if (grant) begin
                beat    <= '0;
                cur_src <= arb_idx;
            end else if (state == ST_BURST) begin
                beat <= beat + 6'd1;
            end
            if (state == ST_GAP) begin
                gap_cnt <= gap_cnt + 4'd1;
            end else begin
                gap_cnt <= '0;
            end
        end
    end

    // One-stage pipeline from the granted source into the scanner.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_vld_in <= 1'b0;
            scan_din    <= '0;
        end else begin
            scan_vld_in <= (state == ST_BURST);
            if (state == ST_BURST) begin
                scan_din <= sel_din;
            end
        end
    end

    // Credits: taken at burst start, returned when the block's last beat leaves.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight <= '0;
        end else begin
            case ({grant, pop})
                2'b10:   inflight <= inflight + 3'd1;
                2'b01:   inflight <= inflight - 3'd1;
                default: inflight <= inflight;
            endcase
        end
    end

    // Source-ID FIFO; occupancy equals inflight, so no separate count is kept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < 4; i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            if (grant) begin
                fifo_mem[wr_ptr] <= arb_idx;
                wr_ptr           <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
        end
    end

    // Register scanner output with its tag; orphan output beats raise err.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_vld  <= 1'b0;
            out_data <= '0;
            out_src  <= '0;
            out_last <= 1'b0;
            out_cnt  <= '0;
            err      <= 1'b0;
        end else begin
            out_vld  <= 1'b0;
            out_last <= 1'b0;
            if (scan_vld_out) begin
                if (fifo_empty) begin
                    err <= 1'b1;
                end else begin
                    out_vld  <= 1'b1;
                    out_data <= scan_dout;
                    out_src  <= fifo_mem[rd_ptr];
                    out_last <= (out_cnt == 6'd63);
                    out_cnt  <= out_cnt + 6'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mat_scan_sched.sv
// Directed bench for mat_scan_sched with a behavioural zigzag scanner and
// raster sources (source 0 supplies 0..63, source 1 supplies 512+0..63).
module tb_mat_scan_sched;

    localparam int N  = 2;
    localparam int DW = 10;
    localparam int EW = 3 + DW + 1;

    logic            clk;
    logic            rst;
    logic            en;
    logic [N-1:0]    req;
    logic [N-1:0]    gnt;
    logic [N*DW-1:0] src_din;
    logic            scan_vld_in;
    logic [DW-1:0]   scan_din;
    logic            scan_vld_out;
    logic [DW-1:0]   scan_dout;
    logic            out_vld;
    logic [DW-1:0]   out_data;
    logic [2:0]      out_src;
    logic            out_last;
    logic [2:0]      inflight;
    logic            busy;
    logic            err;

    int n_chk  = 0;
    int n_pass = 0;

    logic [EW-1:0]  exp_q[$];
    logic [N-1:0]   glog[$];
    logic [DW-1:0]  cap_q[$];
    logic [DW-1:0]  sq[$];
    logic [5:0]     zz[64];
    logic [DW-1:0]  sc_buf[64];
    logic [5:0]     sc_cnt;
    logic [5:0]     src_beat0;
    logic [5:0]     src_beat1;
    logic           cap_en = 1'b0;
    logic           stall  = 1'b0;
    logic           inject = 1'b0;
    int             g_run  = 0;
    logic [N-1:0]   g_prev = '0;
    int             v_run  = 0;
    int             v_max  = 0;
    logic [EW-1:0]  e;

    mat_scan_sched #(.N(N), .DW(DW), .MAX_INFLIGHT(2), .GAP(0)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .req          (req),
        .gnt          (gnt),
        .src_din      (src_din),
        .scan_vld_in  (scan_vld_in),
        .scan_din     (scan_din),
        .scan_vld_out (scan_vld_out),
        .scan_dout    (scan_dout),
        .out_vld      (out_vld),
        .out_data     (out_data),
        .out_src      (out_src),
        .out_last     (out_last),
        .inflight     (inflight),
        .busy         (busy),
        .err          (err)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Sources: sample index advances on every granted cycle.
    always_comb begin
        src_din[0 +: DW]  = {4'd0, src_beat0};
        src_din[DW +: DW] = 10'd512 + {4'd0, src_beat1};
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            src_beat0 <= '0;
            src_beat1 <= '0;
        end else begin
            if (gnt[0]) src_beat0 <= src_beat0 + 6'd1;
            if (gnt[1]) src_beat1 <= src_beat1 + 6'd1;
        end
    end

    // Scanner model: buffer 64 raster samples, then emit them in zigzag order.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sc_cnt       <= '0;
            sq.delete();
            scan_vld_out <= 1'b0;
            scan_dout    <= '0;
        end else begin
            if (scan_vld_in) begin
                sc_buf[sc_cnt] <= scan_din;
                sc_cnt         <= sc_cnt + 6'd1;
                if (sc_cnt == 6'd63) begin
                    for (int i = 0; i < 64; i++) begin
                        sq.push_back((zz[i] == 6'd63) ? scan_din : sc_buf[zz[i]]);
                    end
                end
            end
            if (inject) begin
                scan_vld_out <= 1'b1;
                scan_dout    <= 10'h155;
            end else if (!stall && sq.size() > 0) begin
                scan_vld_out <= 1'b1;
                scan_dout    <= sq.pop_front();
            end else begin
                scan_vld_out <= 1'b0;
            end
        end
    end

    // Monitor: burst lengths, grant log, scan_vld_in contiguity, output scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                g_run  = 0;
                g_prev = '0;
                v_run  = 0;
            end else begin
                if (gnt != g_prev || (gnt != '0 && g_run == 64)) begin
                    if (g_run != 0) chk("burst_len", g_run, 64);
                    g_run = 0;
                    if (gnt != '0) glog.push_back(gnt);
                end
                if (gnt != '0) g_run++;
                g_prev = gnt;
                if (scan_vld_in) v_run++;
                else v_run = 0;
                if (v_run > v_max) v_max = v_run;
                if (out_vld) begin
                    if (cap_en) cap_q.push_back(out_data);
                    if (exp_q.size() == 0) begin
                        chk("out_unexpected", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_data", out_data, e[DW:1]);
                        chk("out_src", out_src, e[EW-1:DW+1]);
                        chk("out_last", out_last, e[0]);
                    end
                end else if (out_last) begin
                    chk("out_last_no_vld", out_last, 0);
                end
            end
        end
    end

    task automatic push_block(input int s);
        logic [DW-1:0] base;
        base = (s == 0) ? 10'd0 : 10'd512;
        for (int i = 0; i < 64; i++) begin
            exp_q.push_back({3'(s), base + {4'd0, zz[i]}, (i == 63)});
        end
    endtask

    function automatic logic [N-1:0] glog_at(input int i);
        return (i < glog.size()) ? glog[i] : '0;
    endfunction

    function automatic logic [DW-1:0] cap_at(input int i);
        return (i < cap_q.size()) ? cap_q[i] : 10'h3FF;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        exp_q.delete();
        glog.delete();
        v_max = 0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_drain(input int max_cyc);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || inflight != 3'd0 || busy) && k < max_cyc) begin
            @(negedge clk);
            k++;
        end
        repeat (2) @(negedge clk);
        chk("drain_q", exp_q.size(), 0);
        chk("drain_inflight", inflight, 0);
    endtask

    task automatic wait_gnt(input int max_cyc);
        int k;
        k = 0;
        while (gnt == '0 && k < max_cyc) begin
            @(negedge clk);
            k++;
        end
    endtask

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end

    // Main directed sequence
    initial begin
        int r;
        int c;
        int k;
        int hi;
        r = 0;
        c = 0;
        for (int i = 0; i < 64; i++) begin
            zz[i] = 6'(r * 8 + c);
            if (((r + c) % 2) == 0) begin
                if (c == 7) r++;
                else if (r == 0) c++;
                else begin r--; c++; end
            end else begin
                if (r == 7) c++;
                else if (c == 0) r++;
                else begin r++; c--; end
            end
        end

        rst = 1'b1;
        en  = 1'b0;
        req = '0;
        repeat (3) @(negedge clk);
        chk("rst_gnt", gnt, 0);
        chk("rst_scan_vld_in", scan_vld_in, 0);
        chk("rst_scan_din", scan_din, 0);
        chk("rst_out_vld", out_vld, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_src", out_src, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_inflight", inflight, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        rst = 1'b0;

        // 1: single source, full block through the scanner
        @(negedge clk);
        en     = 1'b1;
        req    = 2'b01;
        cap_en = 1'b1;
        push_block(0);
        @(negedge clk);
        chk("t1_gnt_first", gnt, 2'b01);
        chk("t1_vld_latency", scan_vld_in, 0);
        chk("t1_inflight", inflight, 1);
        chk("t1_busy", busy, 1);
        req = '0;
        @(negedge clk);
        chk("t1_vld_follow", scan_vld_in, 1);
        wait_drain(400);
        cap_en = 1'b0;
        chk("t1_d0", cap_at(0), 0);
        chk("t1_d1", cap_at(1), 1);
        chk("t1_d2", cap_at(2), 8);
        chk("t1_d3", cap_at(3), 16);
        chk("t1_d4", cap_at(4), 9);
        chk("t1_d61", cap_at(61), 55);
        chk("t1_d62", cap_at(62), 62);
        chk("t1_d63", cap_at(63), 63);
        chk("t1_ngrants", glog.size(), 1);
        chk("t1_contig", v_max, 64);
        chk("t1_busy_end", busy, 0);

        // 2: both sources, back-to-back round robin
        do_reset();
        en  = 1'b1;
        req = 2'b11;
        push_block(0);
        push_block(1);
        push_block(0);
        push_block(1);
        k = 0;
        while (glog.size() < 4 && k < 800) begin
            @(negedge clk);
            k++;
        end
        req = '0;
        chk("t2_ngrants", glog.size(), 4);
        chk("t2_g0", glog_at(0), 2'b01);
        chk("t2_g1", glog_at(1), 2'b10);
        chk("t2_g2", glog_at(2), 2'b01);
        chk("t2_g3", glog_at(3), 2'b10);
        wait_drain(800);
        chk("t2_contig", v_max, 128);

        // 3: credit limit holds the third grant until the first out_last
        do_reset();
        stall = 1'b1;
        en    = 1'b1;
        req   = 2'b01;
        push_block(0);
        push_block(1);
        push_block(0);
        repeat (10) @(negedge clk);
        req = 2'b11;
        k = 0;
        while (glog.size() < 2 && k < 200) begin
            @(negedge clk);
            k++;
        end
        k = 0;
        while (gnt != '0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        hi = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (gnt != '0) hi++;
        end
        chk("t3_hold_gnt", hi, 0);
        chk("t3_g1", glog_at(1), 2'b10);
        chk("t3_inflight_full", inflight, 2);
        chk("t3_busy", busy, 1);
        stall = 1'b0;
        k = 0;
        while (!out_last && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("t3_last_seen", out_last, 1);
        chk("t3_gnt_at_last", gnt, 0);
        chk("t3_inflight_at_last", inflight, 1);
        @(negedge clk);
        chk("t3_gnt_after_last", gnt, 2'b01);
        chk("t3_inflight_regrant", inflight, 2);
        req = '0;
        wait_drain(600);

        // 4: en gates new grants but never cuts a burst
        do_reset();
        en  = 1'b0;
        req = 2'b01;
        hi  = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (gnt != '0) hi++;
        end
        chk("t4_no_gnt", hi, 0);
        chk("t4_busy_idle", busy, 0);
        en = 1'b1;
        push_block(0);
        @(negedge clk);
        chk("t4_gnt_en", gnt, 2'b01);
        hi = 1;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (gnt[0]) hi++;
            if (i == 4) en = 1'b0;
        end
        chk("t4_len", hi, 64);
        chk("t4_ngrants", glog.size(), 1);
        req = '0;
        en  = 1'b1;
        wait_drain(400);

        // 5: reset in mid-burst, then a clean block
        do_reset();
        en  = 1'b1;
        req = 2'b01;
        @(negedge clk);
        chk("t5_gnt_first", gnt, 2'b01);
        repeat (30) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_gnt", gnt, 0);
        chk("t5_rst_vld_in", scan_vld_in, 0);
        chk("t5_rst_inflight", inflight, 0);
        chk("t5_rst_busy", busy, 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        glog.delete();
        push_block(0);
        #2 rst = 1'b0;
        @(negedge clk);
        wait_gnt(20);
        chk("t5_regrant", gnt, 2'b01);
        req = '0;
        wait_drain(400);
        chk("t5_ngrants", glog.size(), 1);

        // 6: orphan scanner output sets sticky err
        do_reset();
        chk("t6_err_clear", err, 0);
        inject = 1'b1;
        @(negedge clk);
        inject = 1'b0;
        @(negedge clk);
        chk("t6_err_set", err, 1);
        chk("t6_no_out_vld", out_vld, 0);
        req = 2'b01;
        push_block(0);
        @(negedge clk);
        wait_gnt(20);
        chk("t6_gnt", gnt, 2'b01);
        req = '0;
        wait_drain(400);
        chk("t6_err_sticky", err, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
